// File: rtl/intra_edge_filter_ctrl.sv
// rtl/intra_edge_filter_ctrl.sv - sequences one shared intra edge filter over aboveRow then leftCol
// Optional macro INTRA_EDGE_SMOOTH_TYPE_EN enables the smooth-neighbour strength table.
module intra_edge_filter_ctrl #(
  parameter int SIZE = 8,
  parameter int PX_W = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       ready,
  input  logic [6:0]                 blk_w,
  input  logic [6:0]                 blk_h,
  input  logic [8:0]                 p_angle,
  input  logic                       filter_type,
  input  logic [PX_W-1:0]            above_ref,
  input  logic [PX_W-1:0]            left_ref,
  input  logic [SIZE-1:0][PX_W-1:0]  above_in,
  input  logic [SIZE-1:0][PX_W-1:0]  left_in,
  output logic [PX_W-1:0]            filt_ref,
  output logic [9:0]                 filt_strength,
  output logic [SIZE-1:0][PX_W-1:0]  filt_in,
  input  logic [SIZE-1:0][PX_W-1:0]  filt_out,
  output logic [SIZE-1:0][PX_W-1:0]  above_out,
  output logic [SIZE-1:0][PX_W-1:0]  left_out,
  output logic [1:0]                 above_str,
  output logic [1:0]                 left_str,
  output logic                       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_FA   = 3'd2;
  localparam logic [2:0] S_CA   = 3'd3;
  localparam logic [2:0] S_FL   = 3'd4;
  localparam logic [2:0] S_CL   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

`ifdef INTRA_EDGE_SMOOTH_TYPE_EN
  localparam logic SMOOTH_EN = 1'b1;
`else
  localparam logic SMOOTH_EN = 1'b0;
`endif

  logic [2:0]                state_q, state_d;
  logic [6:0]                blk_w_q, blk_w_d;
  logic [6:0]                blk_h_q, blk_h_d;
  logic [8:0]                p_angle_q, p_angle_d;
  logic                      type_q, type_d;
  logic [PX_W-1:0]           above_ref_q, above_ref_d;
  logic [PX_W-1:0]           left_ref_q, left_ref_d;
  logic [SIZE-1:0][PX_W-1:0] above_in_q, above_in_d;
  logic [SIZE-1:0][PX_W-1:0] left_in_q, left_in_d;
  logic [1:0]                str_a_q, str_a_d;
  logic [1:0]                str_l_q, str_l_d;
  logic [PX_W-1:0]           filt_ref_q, filt_ref_d;
  logic [9:0]                filt_strength_q, filt_strength_d;
  logic [SIZE-1:0][PX_W-1:0] filt_in_q, filt_in_d;
  logic [SIZE-1:0][PX_W-1:0] above_out_q, above_out_d;
  logic [SIZE-1:0][PX_W-1:0] left_out_q, left_out_d;
  logic [1:0]                above_str_q, above_str_d;
  logic [1:0]                left_str_q, left_str_d;

  logic [7:0] wh;
  logic [8:0] d_a, d_l;
  logic [1:0] str_a_calc, str_l_calc;
  logic       smooth_sel;

  // Thresholds are checked highest strength first, so the first hit wins.
  function automatic logic [1:0] edge_strength(input logic [7:0] w_h, input logic [8:0] d,
                                               input logic smooth);
    logic [1:0] s;
    s = 2'd0;
    if (!smooth) begin
      if (w_h <= 8'd8) begin
        if (d >= 9'd56) s = 2'd1;
      end else if (w_h <= 8'd16) begin
        if (d >= 9'd40) s = 2'd1;
      end else if (w_h <= 8'd24) begin
        if (d >= 9'd32)      s = 2'd3;
        else if (d >= 9'd16) s = 2'd2;
        else if (d >= 9'd8)  s = 2'd1;
      end else if (w_h <= 8'd32) begin
        if (d >= 9'd32)      s = 2'd3;
        else if (d >= 9'd4)  s = 2'd2;
        else if (d >= 9'd1)  s = 2'd1;
      end else begin
        if (d >= 9'd1) s = 2'd3;
      end
    end else begin
      if (w_h <= 8'd8) begin
        if (d >= 9'd64)      s = 2'd2;
        else if (d >= 9'd40) s = 2'd1;
      end else if (w_h <= 8'd16) begin
        if (d >= 9'd48)      s = 2'd2;
        else if (d >= 9'd20) s = 2'd1;
      end else if (w_h <= 8'd24) begin
        if (d >= 9'd4) s = 2'd3;
      end else begin
        if (d >= 9'd1) s = 2'd3;
      end
    end
    return s;
  endfunction

  assign smooth_sel = SMOOTH_EN & type_q;
  assign wh         = {1'b0, blk_w_q} + {1'b0, blk_h_q};
  assign d_a        = (p_angle_q >= 9'd90)  ? (p_angle_q - 9'd90)  : (9'd90 - p_angle_q);
  assign d_l        = (p_angle_q >= 9'd180) ? (p_angle_q - 9'd180) : (9'd180 - p_angle_q);
  assign str_a_calc = edge_strength(wh, d_a, smooth_sel);
  assign str_l_calc = edge_strength(wh, d_l, smooth_sel);

  always_comb begin
    state_d         = state_q;
    blk_w_d         = blk_w_q;
    blk_h_d         = blk_h_q;
    p_angle_d       = p_angle_q;
    type_d          = type_q;
    above_ref_d     = above_ref_q;
    left_ref_d      = left_ref_q;
    above_in_d      = above_in_q;
    left_in_d       = left_in_q;
    str_a_d         = str_a_q;
    str_l_d         = str_l_q;
    filt_ref_d      = filt_ref_q;
    filt_strength_d = 10'd0;
    filt_in_d       = filt_in_q;
    above_out_d     = above_out_q;
    left_out_d      = left_out_q;
    above_str_d     = above_str_q;
    left_str_d      = left_str_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          blk_w_d     = blk_w;
          blk_h_d     = blk_h;
          p_angle_d   = p_angle;
          type_d      = filter_type;
          above_ref_d = above_ref;
          left_ref_d  = left_ref;
          above_in_d  = above_in;
          left_in_d   = left_in;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        // Filter drive is loaded here so it is presented during FA.
        str_a_d         = str_a_calc;
        str_l_d         = str_l_calc;
        filt_ref_d      = above_ref_q;
        filt_in_d       = above_in_q;
        filt_strength_d = {8'd0, str_a_calc};
        state_d         = S_FA;
      end
      S_FA: state_d = S_CA;
      S_CA: begin
        above_out_d     = (str_a_q == 2'd0) ? above_in_q : filt_out;
        above_str_d     = str_a_q;
        filt_ref_d      = left_ref_q;
        filt_in_d       = left_in_q;
        filt_strength_d = {8'd0, str_l_q};
        state_d         = S_FL;
      end
      S_FL: state_d = S_CL;
      S_CL: begin
        left_out_d = (str_l_q == 2'd0) ? left_in_q : filt_out;
        left_str_d = str_l_q;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      blk_w_q         <= '0;
      blk_h_q         <= '0;
      p_angle_q       <= '0;
      type_q          <= 1'b0;
      above_ref_q     <= '0;
      left_ref_q      <= '0;
      above_in_q      <= '0;
      left_in_q       <= '0;
      str_a_q         <= '0;
      str_l_q         <= '0;
      filt_ref_q      <= '0;
      filt_strength_q <= '0;
      filt_in_q       <= '0;
      above_out_q     <= '0;
      left_out_q      <= '0;
      above_str_q     <= '0;
      left_str_q      <= '0;
    end else begin
      state_q         <= state_d;
      blk_w_q         <= blk_w_d;
      blk_h_q         <= blk_h_d;
      p_angle_q       <= p_angle_d;
      type_q          <= type_d;
      above_ref_q     <= above_ref_d;
      left_ref_q      <= left_ref_d;
      above_in_q      <= above_in_d;
      left_in_q       <= left_in_d;
      str_a_q         <= str_a_d;
      str_l_q         <= str_l_d;
      filt_ref_q      <= filt_ref_d;
      filt_strength_q <= filt_strength_d;
      filt_in_q       <= filt_in_d;
      above_out_q     <= above_out_d;
      left_out_q      <= left_out_d;
      above_str_q     <= above_str_d;
      left_str_q      <= left_str_d;
    end
  end

  assign ready         = (state_q == S_IDLE);
  assign done          = (state_q == S_DONE);
  assign filt_ref      = filt_ref_q;
  assign filt_strength = filt_strength_q;
  assign filt_in       = filt_in_q;
  assign above_out     = above_out_q;
  assign left_out      = left_out_q;
  assign above_str     = above_str_q;
  assign left_str      = left_str_q;

endmodule

// File: tb/tb_intra_edge_filter_ctrl.sv
// tb/tb_intra_edge_filter_ctrl.sv - self-checking bench for intra_edge_filter_ctrl with a stand-in filter
module tb_intra_edge_filter_ctrl;
  localparam int SIZE = 8;
  localparam int PX_W = 30;
  localparam int NONE = 1000;

  typedef logic [SIZE-1:0][PX_W-1:0] edge_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, ready, filter_type, done;
  logic [6:0]      blk_w, blk_h;
  logic [8:0]      p_angle;
  logic [PX_W-1:0] above_ref, left_ref, filt_ref;
  logic [9:0]      filt_strength;
  edge_t           above_in, left_in, filt_in, filt_out, above_out, left_out;
  logic [1:0]      above_str, left_str;

  intra_edge_filter_ctrl #(.SIZE(SIZE), .PX_W(PX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .blk_w(blk_w), .blk_h(blk_h), .p_angle(p_angle), .filter_type(filter_type),
    .above_ref(above_ref), .left_ref(left_ref), .above_in(above_in), .left_in(left_in),
    .filt_ref(filt_ref), .filt_strength(filt_strength), .filt_in(filt_in), .filt_out(filt_out),
    .above_out(above_out), .left_out(left_out), .above_str(above_str), .left_str(left_str),
    .done(done)
  );

  // Stand-in for the filter: position, strength and reference all perturb the result.
  function automatic edge_t fake_filt(input edge_t in, input logic [9:0] st, input logic [PX_W-1:0] r);
    edge_t o;
    for (int i = 0; i < SIZE; i++)
      o[i] = (in[i] + PX_W'(int'(st) * 16 + i)) ^ {r[PX_W-2:0], r[PX_W-1]};
    return o;
  endfunction

  always @(posedge clk) filt_out <= fake_filt(filt_in, filt_strength, filt_ref);

  // Strength tables as rows: {upper wh bound} and thresholds for strength 3, 2, 1.
  localparam int LIM [5] = '{8, 16, 24, 32, NONE};
  localparam int T0 [5][3] = '{'{NONE, NONE, 56}, '{NONE, NONE, 40}, '{32, 16, 8},
                               '{32, 4, 1}, '{1, NONE, NONE}};
  localparam int T1 [5][3] = '{'{NONE, 64, 40}, '{NONE, 48, 20}, '{4, NONE, NONE},
                               '{1, NONE, NONE}, '{1, NONE, NONE}};

  function automatic int model_str(input int wh, input int d, input int typ);
    int r;
    int t [3];
    r = 0;
    while (wh > LIM[r]) r++;
    for (int k = 0; k < 3; k++) t[k] = (typ != 0) ? T1[r][k] : T0[r][k];
    if (d >= t[0]) return 3;
    if (d >= t[1]) return 2;
    if (d >= t[2]) return 1;
    return 0;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Job-level reference: ph counts cycles since acceptance (0 = idle).
  int        ph = 0;
  int        m_sa, m_sl;
  edge_t     m_above, m_left, e_fin, e_aout, e_lout;
  logic [PX_W-1:0] m_aref, m_lref, e_fref;
  int        e_astr, e_lstr;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        ph = 0; e_fin = '0; e_fref = '0; e_aout = '0; e_lout = '0; e_astr = 0; e_lstr = 0;
      end else begin
        if (ph == 0) begin
          if (start) begin
            int typ;
`ifdef INTRA_EDGE_SMOOTH_TYPE_EN
            typ = int'(filter_type);
`else
            typ = 0;
`endif
            m_sa = model_str(int'(blk_w) + int'(blk_h), iabs(int'(p_angle) - 90), typ);
            m_sl = model_str(int'(blk_w) + int'(blk_h), iabs(int'(p_angle) - 180), typ);
            m_above = above_in; m_left = left_in; m_aref = above_ref; m_lref = left_ref;
            ph = 1;
          end
        end else begin
          ph = (ph == 6) ? 0 : ph + 1;
        end
        if (ph == 2) begin e_fin = m_above; e_fref = m_aref; end
        if (ph == 4) begin
          e_fin = m_left; e_fref = m_lref; e_astr = m_sa;
          e_aout = (m_sa == 0) ? m_above : fake_filt(m_above, 10'(m_sa), m_aref);
        end
        if (ph == 6) begin
          e_lstr = m_sl;
          e_lout = (m_sl == 0) ? m_left : fake_filt(m_left, 10'(m_sl), m_lref);
        end
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 256'(ready), 256'(ph == 0));
      chk("done", 256'(done), 256'(ph == 6));
      chk("filt_strength", 256'(filt_strength),
          256'((ph == 2) ? m_sa : (ph == 4) ? m_sl : 0));
      chk("filt_in", 256'(filt_in), 256'(e_fin));
      chk("filt_ref", 256'(filt_ref), 256'(e_fref));
      chk("above_out", 256'(above_out), 256'(e_aout));
      chk("left_out", 256'(left_out), 256'(e_lout));
      chk("above_str", 256'(above_str), 256'(e_astr));
      chk("left_str", 256'(left_str), 256'(e_lstr));
    end
  end

  task automatic rand_inputs();
    int sel;
    sel = $urandom_range(0, 5);
    blk_w = (sel == 5) ? 7'($urandom) : 7'(4 << sel);
    sel = $urandom_range(0, 5);
    blk_h = (sel == 5) ? 7'($urandom) : 7'(4 << sel);
    p_angle = 9'($urandom_range(0, 270));
    filter_type = 1'($urandom);
    above_ref = PX_W'($urandom);
    left_ref = PX_W'($urandom);
    for (int i = 0; i < SIZE; i++) begin
      above_in[i] = PX_W'($urandom);
      left_in[i] = PX_W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (ph != 0 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) chk("idle_timeout", 256'(ph), 256'(0));
  endtask

  // Runs one job from idle; reports first-done latency, done count and busy cycles.
  task automatic run_job(input int w, input int h, input int ang, input logic typ,
                         input logic [PX_W-1:0] ar, input logic [PX_W-1:0] lr,
                         input edge_t ai, input edge_t li, input bit busy_start,
                         output int lat, output int ndone, output int nbusy);
    wait_idle();
    blk_w = 7'(w); blk_h = 7'(h); p_angle = 9'(ang); filter_type = typ;
    above_ref = ar; left_ref = lr; above_in = ai; left_in = li;
    start = 1'b1;
    lat = 0; ndone = 0; nbusy = 0;
    @(negedge clk);
    start = 1'b0;
    rand_inputs();
    for (int k = 1; k <= 12; k++) begin
      if (done) begin ndone++; if (lat == 0) lat = k; end
      if (!ready && k <= 6) nbusy++;
      start = (busy_start && k == 2);
      @(negedge clk);
      rand_inputs();
    end
    start = 1'b0;
  endtask

  edge_t flat, ramp, rnd;
  int lat, nd, nb;

  initial begin
    reset = 1'b1; start = 1'b0;
    rand_inputs();
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(ready), 256'(1));
    chk("rst_above_out", 256'(above_out), 256'(0));
    reset = 1'b0;

    for (int i = 0; i < SIZE; i++) begin
      flat[i] = {10'd100, 10'd100, 10'd100};
      ramp[i] = PX_W'(i);
      rnd[i]  = PX_W'($urandom);
    end

    run_job(8, 8, 135, 1'b0, flat[0], flat[0], flat, flat, 1'b0, lat, nd, nb);
    chk("t1_latency", 256'(lat), 256'(6));
    chk("t1_above_str", 256'(above_str), 256'(1));
    chk("t1_left_str", 256'(left_str), 256'(1));

    run_job(4, 4, 90, 1'b0, 30'h5, 30'h9, ramp, rnd, 1'b0, lat, nd, nb);
    chk("t2_above_str", 256'(above_str), 256'(0));
    chk("t2_above_bypass", 256'(above_out), 256'(ramp));
    chk("t2_left_str", 256'(left_str), 256'(1));

    run_job(16, 16, 93, 1'b0, 30'h1, 30'h2, rnd, ramp, 1'b0, lat, nd, nb);
    chk("t3a_above_str", 256'(above_str), 256'(1));
    chk("t3a_left_str", 256'(left_str), 256'(3));

    run_job(32, 32, 180, 1'b0, 30'h3, 30'h4, rnd, ramp, 1'b0, lat, nd, nb);
    chk("t3b_above_str", 256'(above_str), 256'(3));
    chk("t3b_left_str", 256'(left_str), 256'(0));
    chk("t3b_left_bypass", 256'(left_out), 256'(ramp));

    run_job(8, 8, 113, 1'b1, 30'h7, 30'h8, rnd, rnd, 1'b0, lat, nd, nb);
`ifdef INTRA_EDGE_SMOOTH_TYPE_EN
    chk("t4_above_str", 256'(above_str), 256'(1));
    chk("t4_left_str", 256'(left_str), 256'(2));
`else
    chk("t4_above_str", 256'(above_str), 256'(0));
    chk("t4_left_str", 256'(left_str), 256'(1));
`endif

    run_job(8, 16, 200, 1'b0, 30'hA, 30'hB, rnd, ramp, 1'b1, lat, nd, nb);
    chk("t5_one_done", 256'(nd), 256'(1));
    chk("t5_busy_cycles", 256'(nb), 256'(6));
    chk("t5_latency", 256'(lat), 256'(6));

    // Abort in FL, then a clean job.
    wait_idle();
    blk_w = 7'd16; blk_h = 7'd16; p_angle = 9'd45; filter_type = 1'b0;
    above_ref = 30'h11; left_ref = 30'h22; above_in = rnd; left_in = ramp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_in_fl", 256'(filt_strength != 10'd0), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_ready", 256'(ready), 256'(1));
    chk("t6_done", 256'(done), 256'(0));
    chk("t6_above_out", 256'(above_out), 256'(0));
    chk("t6_filt_in", 256'(filt_in), 256'(0));
    run_job(16, 16, 45, 1'b0, 30'h11, 30'h22, rnd, ramp, 1'b0, lat, nd, nb);
    chk("t6_restart_latency", 256'(lat), 256'(6));
    chk("t6_restart_done", 256'(nd), 256'(1));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      rand_inputs();
    end
    start = 1'b0; reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
